// File: rtl/soc_glip_dii_pkg.sv
// Shared types and default sizes for the GLIP <-> DII framing bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package soc_glip_dii_pkg;

    localparam int DEF_FLIT_WIDTH  = 16;
    localparam int DEF_MAX_PKT_LEN = 12;

    typedef enum logic [1:0] {
        E_COLLECT,
        E_HDR,
        E_PAYLOAD,
        E_DROP
    } egress_state_t;

    typedef enum logic {
        I_LEN,
        I_DATA
    } ingress_state_t;

endpackage

// File: rtl/soc_glip_dii_bridge_if.sv
// Handshake bundle between host DII streams and system GLIP word channels.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on all four streams; the sender holds valid+data until the transfer.
// Modports: master = host/system environment, slave = the bridge.
//   dii_in_*   host -> bridge flits          glip_out_* bridge -> system c_glip_in
//   glip_in_*  system c_glip_out -> bridge   dii_out_*  bridge -> host flits
//   err_*      sticky status from the bridge
interface soc_glip_dii_bridge_if
    import soc_glip_dii_pkg::*;
#(
    parameter int FLIT_WIDTH = DEF_FLIT_WIDTH
);
    logic [FLIT_WIDTH-1:0] dii_in_data;
    logic                  dii_in_last;
    logic                  dii_in_valid;
    logic                  dii_in_ready;

    logic [FLIT_WIDTH-1:0] glip_out_data;
    logic                  glip_out_valid;
    logic                  glip_out_ready;

    logic [FLIT_WIDTH-1:0] glip_in_data;
    logic                  glip_in_valid;
    logic                  glip_in_ready;

    logic [FLIT_WIDTH-1:0] dii_out_data;
    logic                  dii_out_last;
    logic                  dii_out_valid;
    logic                  dii_out_ready;

    logic                  err_overflow;
    logic                  err_len_zero;

    modport master (
        output dii_in_data, dii_in_last, dii_in_valid,
        input  dii_in_ready,
        input  glip_out_data, glip_out_valid,
        output glip_out_ready,
        output glip_in_data, glip_in_valid,
        input  glip_in_ready,
        input  dii_out_data, dii_out_last, dii_out_valid,
        output dii_out_ready,
        input  err_overflow, err_len_zero
    );

    modport slave (
        input  dii_in_data, dii_in_last, dii_in_valid,
        output dii_in_ready,
        output glip_out_data, glip_out_valid,
        input  glip_out_ready,
        input  glip_in_data, glip_in_valid,
        output glip_in_ready,
        output dii_out_data, dii_out_last, dii_out_valid,
        input  dii_out_ready,
        output err_overflow, err_len_zero
    );

endinterface

// File: rtl/soc_glip_dii_pktbuf.sv
// Single-packet flit store: one write port, one combinational read port, storage not reset.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner sequences reads and writes.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port (out-of-range reads return 0).
module soc_glip_dii_pktbuf #(
    parameter int DEPTH = 12,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The owner prefetches one past the last flit; that address may fall outside the array.
    assign o_rdata = (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/soc_glip_dii_bridge.sv
// Host-side framing bridge: DII packets <-> length-prefixed 16-bit GLIP word streams.
// Latency: egress length word valid the cycle after the last flit is accepted; ingress is zero-latency pass-through.
// Backpressure: egress stops accepting flits while a packet drains; ingress data stalls follow dii_out_ready.
// Ports: clk, rst (async active-low); bus = slave side of soc_glip_dii_bridge_if.
module soc_glip_dii_bridge
    import soc_glip_dii_pkg::*;
#(
    parameter int FLIT_WIDTH  = DEF_FLIT_WIDTH,
    parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    soc_glip_dii_bridge_if.slave bus
);

    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam int AW = $clog2(MAX_PKT_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT_LEN - 1);

    // ---------------- egress ----------------
    egress_state_t         r_e_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_rd;
    logic [FLIT_WIDTH-1:0] r_glip_out_data;
    logic                  r_glip_out_valid;
    logic                  r_err_overflow;

    logic                  w_dii_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_buf_we;
    logic [CW-1:0]         w_cnt_inc;
    logic [CW-1:0]         w_rd_next;
    logic [AW-1:0]         w_buf_raddr;
    logic [FLIT_WIDTH-1:0] w_buf_rdata;

    assign w_dii_in_ready = (r_e_state == E_COLLECT) || (r_e_state == E_DROP);
    assign w_in_fire      = bus.dii_in_valid && w_dii_in_ready;
    assign w_out_fire     = r_glip_out_valid && bus.glip_out_ready;
    assign w_buf_we       = w_in_fire && (r_e_state == E_COLLECT);
    assign w_cnt_inc      = r_cnt + 1'b1;
    assign w_rd_next      = r_rd + 1'b1;

    // The output word is registered, so the read port always looks one flit ahead:
    // flit 0 while the length word is on the bus, rd+1 while flit rd is on the bus.
    assign w_buf_raddr = (r_e_state == E_HDR) ? '0 : w_rd_next[AW-1:0];

    soc_glip_dii_pktbuf #(
        .DEPTH (MAX_PKT_LEN),
        .WIDTH (FLIT_WIDTH),
        .AW    (AW)
    ) u_pktbuf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_cnt[AW-1:0]),
        .i_wdata (bus.dii_in_data),
        .i_raddr (w_buf_raddr),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e_state        <= E_COLLECT;
            r_cnt            <= '0;
            r_rd             <= '0;
            r_glip_out_data  <= '0;
            r_glip_out_valid <= 1'b0;
            r_err_overflow   <= 1'b0;
        end else begin
            case (r_e_state)
                E_COLLECT: begin
                    if (w_in_fire) begin
                        r_cnt <= w_cnt_inc;
                        // A last flit in the final slot still completes a full-size packet.
                        if (bus.dii_in_last) begin
                            r_e_state        <= E_HDR;
                            r_glip_out_data  <= FLIT_WIDTH'(w_cnt_inc);
                            r_glip_out_valid <= 1'b1;
                        end else if (r_cnt == LAST_IDX) begin
                            r_e_state      <= E_DROP;
                            r_err_overflow <= 1'b1;
                        end
                    end
                end
                E_HDR: begin
                    if (w_out_fire) begin
                        r_e_state       <= E_PAYLOAD;
                        r_rd            <= '0;
                        r_glip_out_data <= w_buf_rdata;
                    end
                end
                E_PAYLOAD: begin
                    if (w_out_fire) begin
                        if (r_rd == r_cnt - 1'b1) begin
                            r_e_state        <= E_COLLECT;
                            r_cnt            <= '0;
                            r_glip_out_valid <= 1'b0;
                        end else begin
                            r_rd            <= w_rd_next;
                            r_glip_out_data <= w_buf_rdata;
                        end
                    end
                end
                E_DROP: begin
                    if (w_in_fire && bus.dii_in_last) begin
                        r_e_state <= E_COLLECT;
                        r_cnt     <= '0;
                    end
                end
                default: begin
                    r_e_state <= E_COLLECT;
                end
            endcase
        end
    end

    assign bus.dii_in_ready   = w_dii_in_ready;
    assign bus.glip_out_data  = r_glip_out_data;
    assign bus.glip_out_valid = r_glip_out_valid;
    assign bus.err_overflow   = r_err_overflow;

    // ---------------- ingress ----------------
    ingress_state_t        r_i_state;
    logic [FLIT_WIDTH-1:0] r_rem;
    logic                  r_err_len_zero;

    logic                  w_in_data_phase;

    assign w_in_data_phase = (r_i_state == I_DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_state      <= I_LEN;
            r_rem          <= '0;
            r_err_len_zero <= 1'b0;
        end else begin
            case (r_i_state)
                I_LEN: begin
                    if (bus.glip_in_valid) begin
                        if (bus.glip_in_data != '0) begin
                            r_rem     <= bus.glip_in_data;
                            r_i_state <= I_DATA;
                        end else begin
                            r_err_len_zero <= 1'b1;
                        end
                    end
                end
                I_DATA: begin
                    if (bus.glip_in_valid && bus.dii_out_ready) begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == FLIT_WIDTH'(1)) begin
                            r_i_state <= I_LEN;
                        end
                    end
                end
                default: begin
                    r_i_state <= I_LEN;
                end
            endcase
        end
    end

    // Length words are swallowed here; payload words pass straight through.
    assign bus.glip_in_ready = w_in_data_phase ? bus.dii_out_ready : 1'b1;
    assign bus.dii_out_valid = w_in_data_phase && bus.glip_in_valid;
    assign bus.dii_out_data  = bus.glip_in_data;
    assign bus.dii_out_last  = w_in_data_phase && (r_rem == FLIT_WIDTH'(1));
    assign bus.err_len_zero  = r_err_len_zero;

endmodule

// File: doc/soc_glip_dii_bridge.md
# soc_glip_dii_bridge

Host-side framing bridge between debug DII flit streams and the 16-bit GLIP word channels of the mpsoc4d_riscv system. Egress: buffers each host DII packet, then sends it on the system GLIP input as a length word followed by payload. Ingress: takes length-prefixed words from the system GLIP output and rebuilds DII packets with `last`. Instantiated in the system testbench and FPGA host wrappers, directly attached to `c_glip_in` / `c_glip_out`.

## Interface
- `FLIT_WIDTH`, 16, DII flit and GLIP word width.
- `MAX_PKT_LEN`, 12, maximum egress packet length in flits; matches DEBUG_MAX_PKT_LEN.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `dii_in_data`  in  FLIT_WIDTH  host-to-system flit.
- `dii_in_last`  in  1  final flit of packet.
- `dii_in_valid` / `dii_in_ready`  in / out  1  host flit handshake.
- `glip_out_data`  out  FLIT_WIDTH  word to system `c_glip_in`.
- `glip_out_valid` / `glip_out_ready`  out / in  1.
- `glip_in_data`  in  FLIT_WIDTH  word from system `c_glip_out`.
- `glip_in_valid` / `glip_in_ready`  in / out  1.
- `dii_out_data`, `dii_out_last`  out  FLIT_WIDTH, 1  system-to-host flit.
- `dii_out_valid` / `dii_out_ready`  out / in  1.
- `err_overflow`, `err_len_zero`  out  1 each  sticky error flags.

## Operation
- All handshakes: a transfer occurs on a rising edge with valid&ready both high. Once a sender asserts valid, it holds valid and data until the transfer.
- Egress FSM states:
  - E_COLLECT: `dii_in_ready`=1. Each accepted flit is written to the buffer at index `cnt`, then `cnt`++.
    - Accepted flit with `last` → E_HDR.
    - Flit accepted at `cnt`==MAX_PKT_LEN-1 without `last` → E_DROP, and `err_overflow` is set.
  - E_HDR: `glip_out_data`=`cnt` (zero-extended), valid=1. On transfer → E_PAYLOAD with read index 0.
  - E_PAYLOAD: presents buffer[rd]. On the transfer with rd==cnt-1 → E_COLLECT, with `cnt`=0.
  - E_DROP: `dii_in_ready`=1 and all flits are discarded. An accepted `last` → E_COLLECT with `cnt`=0. The buffered partial packet is never sent.
- `dii_in_ready`=0 in E_HDR and E_PAYLOAD. Only one packet is buffered at a time.
- Ingress FSM states:
  - I_LEN: `glip_in_ready`=1 and `dii_out_valid`=0.
    - Accepted word w≠0 → `rem`=w, go to I_DATA.
    - Accepted word w=0 → stay in I_LEN, set `err_len_zero`.
  - I_DATA: pass-through. `dii_out_data`=`glip_in_data`, `dii_out_valid`=`glip_in_valid`, `glip_in_ready`=`dii_out_ready`, and `dii_out_last`=(`rem`==1).
    - Each transfer decrements `rem`. The transfer with `rem`==1 → I_LEN.
- Ingress lengths above MAX_PKT_LEN are forwarded unchanged; the full 16-bit `rem` is used.
- The egress and ingress paths are fully independent and may transfer in the same cycle.
- Error flags clear only on reset.

## Timing
- Reset values:
  - FSMs in E_COLLECT and I_LEN; `cnt`, `rd`, `rem` = 0.
  - `glip_out_valid`=0, `dii_out_valid`=0, `dii_out_last`=0, errors=0.
  - `dii_in_ready`=1 and `glip_in_ready`=1 once reset deasserts.
- Egress latency: the length word is valid the cycle after `last` is accepted. Payload follows back-to-back while `glip_out_ready`=1. Minimum N-flit packet occupancy is N+1+N cycles.
- `glip_out_data` and `glip_out_valid` are registered.
- Ingress data path is combinational, with zero latency. `dii_out_valid` is gated to 0 in I_LEN.
- A length word is consumed in one cycle; there is no bubble between the length word and the first flit.
- Reset asserted mid-packet aborts both FSMs immediately and asynchronously. Partial packets are lost and nothing is replayed.

## Structure
- Package `soc_glip_dii_pkg` holds:
  - `egress_state_t` {E_COLLECT, E_HDR, E_PAYLOAD, E_DROP} and `ingress_state_t` {I_LEN, I_DATA};
  - the default `FLIT_WIDTH`.
- Sub-module `soc_glip_dii_pktbuf`: MAX_PKT_LEN×FLIT_WIDTH register array, one write port and one read port, with no reset on storage.
- The top level contains both FSMs and their counters.

## Test plan
- Egress 3-flit packet 0x1111, 0x2222, 0x3333(last), with `glip_out_ready`=1 → GLIP output 0x0003, 0x1111, 0x2222, 0x3333 on consecutive cycles; `dii_in_ready` is low for 4 cycles.
- Egress 12 flits without `last`, then 2 more flits ending in `last` → no GLIP output, `err_overflow`=1; a following 1-flit packet 0xBEEF emits 0x0001, 0xBEEF.
- Ingress words 0x0002, 0xAAAA, 0x5555 → DII 0xAAAA (last=0), then 0x5555 (last=1).
- Ingress word 0x0000, then 0x0001, 0x1234 → `err_len_zero`=1; DII outputs 0x1234 with last=1.
- Both directions run simultaneously with random ready/valid stalls on all four handshakes → no data lost or duplicated, and the scoreboard matches.
- Reset pulsed during E_PAYLOAD and during I_DATA → all outputs return to reset values immediately, and the next packet frames correctly.
